alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Sequencer and arbiter that shares the single 32-bit ALU datapath (operand pair, 2-bit aluOp, 6-bit funct, 32-bit result, 2-bit overflow flag) between two requesters. It accepts one operation at a time through a req/ack handshake, latches the operands and control, and holds them stable on the ALU inputs for a configurable settle window. It then captures result and overflow and returns them with a one-cycle valid pulse tagged with the requester ID. It sits between the ALU and its two clients, e.g. the decode/execute stage and a multi-cycle helper unit.

## Interface
- WAIT_CYCLES, 1, cycles ALU inputs are held before capture; legal 1..15; 0 behaves as 1
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- req0 / req1  in  1  request from requester 0 / 1; held with operands until ack
- ack0 / ack1  out  1  combinational; high in the cycle the request is accepted
- opA0, opB0 / opA1, opB1  in  32 each  signed operands
- aluOp0 / aluOp1  in  2  ALU op class
- funct0 / funct1  in  6  R-type function code
- aluInput1, aluInput2  out  32  to ALU operand ports
- aluOpOut  out  2  to ALU aluOp
- functOut  out  6  to ALU funct
- aluResult  in  32  from ALU result
- aluOverflow  in  2  from ALU overflow flag
- result  out  32  captured result
- overflow  out  2  captured overflow flag
- resultValid  out  1  one-cycle pulse
- resultId  out  1  requester owning result
- busy  out  1  high whenever state is not IDLE
- ovfSticky  out  2  (macro only) per-requester sticky overflow
- ovfClear  in  2  (macro only) per-requester clear

## Operation
- States: IDLE, EXEC, DONE.
- IDLE: with no req, stay. With one req, grant it. With both, grant the requester selected by the priority pointer `prio`.
  - Grant: assert ackN, latch opA/opB/aluOp/funct into the ALU-drive registers, record the owner, load the counter with WAIT_CYCLES-1, and go to EXEC.
  - After a grant, set `prio` to the non-granted requester (round-robin).
- EXEC: ALU drive registers held. When the counter is 0, capture aluResult into `result` and aluOverflow into `overflow`, then go to DONE. Otherwise decrement the counter.
- DONE: resultValid=1, resultId=owner. ALU drive registers still held. Next state is IDLE unconditionally; no grant is made in DONE.
- `result`, `overflow` and `resultId` keep their values until the next capture. The ALU drive registers keep their values until the next grant.
- Overflow is passed through unmodified. The ALU reports it only for add/sub.
- No ack is asserted outside IDLE. A req arriving during EXEC/DONE waits.

## Timing
- Reset values: all ALU drive outputs 0, result 0, overflow 0, resultValid 0, resultId 0, ack0/ack1 0, busy 0, state IDLE, prio 0, counter 0.
- Grant (ack high) in cycle T. aluInput*/aluOpOut/functOut are valid from T+1. EXEC spans T+1..T+WAIT_CYCLES. resultValid is high in cycle T+WAIT_CYCLES+1.
- Throughput: one operation per WAIT_CYCLES+2 cycles. The next grant is possible at T+WAIT_CYCLES+2.
- Simultaneous req0 and req1 on the first grant after reset: requester 0 wins.
- Reset asserted in any state:
  - The next cycle is IDLE with reset values.
  - An in-flight operation is dropped with no resultValid.
  - prio returns to 0.
- A requester deasserting req before ack is legal; the request is withdrawn.
- The ALU is treated as combinational. aluResult is sampled only on the final EXEC edge.

## Configuration
- ALU_ARB_OVF_STICKY_EN defined:
  - ovfSticky/ovfClear ports exist. ovfSticky[N] sets at the DONE cycle edge when resultId==N and overflow!=0. ovfClear[N] clears it.
  - Simultaneous set and clear: set wins.
  - Reset value 0.
- Undefined: the ports and registers are absent. All other behaviour is identical.

## Test plan
- Reset, then idle 10 cycles with no req -> every output 0, busy 0, no ack.
- WAIT_CYCLES=1; req0 with opA0=5, opB0=7, aluOp0=2, funct0=32 -> ack0 at T, aluInput1=5/aluInput2=7/functOut=32 from T+1, resultValid at T+2 with result=12, resultId=0, overflow=0.
- req0 and req1 both held continuously, each with distinct SUB operands -> grants alternate 0,1,0,1 and each resultValid carries the matching resultId and difference.
- 0x7FFFFFFF + 1 (ADD) from requester 1 -> result 0x80000000, overflow!=0. With the macro: ovfSticky[1]=1 and ovfSticky[0]=0; ovfClear[1] pulsed together with a new overflowing result keeps ovfSticky[1]=1.
- WAIT_CYCLES=3, grant at T -> ALU drive outputs constant T+1..T+4, resultValid exactly at T+4; a req1 raised at T+2 is acked at T+5.
- Reset asserted at T+1 of a WAIT_CYCLES=3 operation -> no resultValid, all outputs 0 at T+2; a subsequent simultaneous req0/req1 grants requester 0.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters,
// holding operands for a settle window and returning a tagged result.
//
// Ports:
//   clock, reset            rising-edge clock, synchronous active-high reset
//   req0/req1, ack0/ack1    request and combinational accept per requester
//   opA*/opB*/aluOp*/funct* operands and control per requester
//   aluInput1/2, aluOpOut,
//   functOut                registered drive to the ALU
//   aluResult, aluOverflow  combinational ALU outputs
//   result, overflow,
//   resultValid, resultId   captured result, one-cycle valid pulse, owner
//   busy                    high whenever an operation is in flight
//   ovfSticky, ovfClear     per-requester sticky overflow (ALU_ARB_OVF_STICKY_EN)
//
// Parameter WAIT_CYCLES: cycles the ALU inputs settle before capture
// (1..15, 0 is treated as 1).
// Optional macro ALU_ARB_OVF_STICKY_EN adds the sticky overflow ports.

module alu_arbiter #(
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    output logic        ack0,
    output logic        ack1,
    input  logic [31:0] opA0,
    input  logic [31:0] opB0,
    input  logic [1:0]  aluOp0,
    input  logic [5:0]  funct0,
    input  logic [31:0] opA1,
    input  logic [31:0] opB1,
    input  logic [1:0]  aluOp1,
    input  logic [5:0]  funct1,
    output logic [31:0] aluInput1,
    output logic [31:0] aluInput2,
    output logic [1:0]  aluOpOut,
    output logic [5:0]  functOut,
    input  logic [31:0] aluResult,
    input  logic [1:0]  aluOverflow,
    output logic [31:0] result,
    output logic [1:0]  overflow,
    output logic        resultValid,
    output logic        resultId,
`ifdef ALU_ARB_OVF_STICKY_EN
    output logic [1:0]  ovfSticky,
    input  logic [1:0]  ovfClear,
`endif
    output logic        busy
);

    localparam int WEFF = (WAIT_CYCLES < 1)  ? 1  :
                          (WAIT_CYCLES > 15) ? 15 : WAIT_CYCLES;
    localparam logic [3:0] CNT_LOAD = 4'(WEFF - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic       prio;
    logic       owner;
    logic [3:0] cnt;

    // Grant decision; prio names the requester that wins a tie.
    always_comb begin
        state_nxt = state;
        ack0      = 1'b0;
        ack1      = 1'b0;
        unique case (state)
            IDLE: begin
                if (!reset) begin
                    if (req0 && (!req1 || !prio)) begin
                        ack0 = 1'b1;
                    end else if (req1) begin
                        ack1 = 1'b1;
                    end
                end
                if (ack0 || ack1) begin
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                if (cnt == 4'd0) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            prio      <= 1'b0;
            owner     <= 1'b0;
            cnt       <= 4'd0;
            aluInput1 <= 32'd0;
            aluInput2 <= 32'd0;
            aluOpOut  <= 2'd0;
            functOut  <= 6'd0;
            result    <= 32'd0;
            overflow  <= 2'd0;
            resultId  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (ack0) begin
                aluInput1 <= opA0;
                aluInput2 <= opB0;
                aluOpOut  <= aluOp0;
                functOut  <= funct0;
                owner     <= 1'b0;
                cnt       <= CNT_LOAD;
                prio      <= 1'b1;
            end else if (ack1) begin
                aluInput1 <= opA1;
                aluInput2 <= opB1;
                aluOpOut  <= aluOp1;
                functOut  <= funct1;
                owner     <= 1'b1;
                cnt       <= CNT_LOAD;
                prio      <= 1'b0;
            end
            if (state == EXEC) begin
                if (cnt == 4'd0) begin
                    result   <= aluResult;
                    overflow <= aluOverflow;
                    resultId <= owner;
                end else begin
                    cnt <= cnt - 4'd1;
                end
            end
        end
    end

    assign resultValid = (state == DONE);
    assign busy        = (state != IDLE);

`ifdef ALU_ARB_OVF_STICKY_EN
    // Set takes priority over clear so a fresh overflow is never lost.
    always_ff @(posedge clock) begin
        if (reset) begin
            ovfSticky <= 2'd0;
        end else begin
            for (int n = 0; n < 2; n++) begin
                if (state == DONE && resultId == n[0] && overflow != 2'd0) begin
                    ovfSticky[n] <= 1'b1;
                end else if (ovfClear[n]) begin
                    ovfSticky[n] <= 1'b0;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed checks of alu_arbiter with WAIT_CYCLES=1
// and WAIT_CYCLES=3 instances driven by a small behavioural ALU.

module tb_alu_arbiter;

    logic        clock;
    logic        reset1, reset3;
    logic        req0, req1;
    logic [31:0] opA0, opB0, opA1, opB1;
    logic [1:0]  aluOp0, aluOp1;
    logic [5:0]  funct0, funct1;
    logic [1:0]  ovfClear;

    logic        ack0_1, ack1_1, rv_1, rid_1, busy_1;
    logic [31:0] in1_1, in2_1, res_1, aluRes_1;
    logic [1:0]  op_1, ovf_1, aluOvf_1, sticky_1;
    logic [5:0]  fn_1;

    logic        ack0_3, ack1_3, rv_3, rid_3, busy_3;
    logic [31:0] in1_3, in2_3, res_3, aluRes_3;
    logic [1:0]  op_3, ovf_3, aluOvf_3, sticky_3;
    logic [5:0]  fn_3;

    int checks   = 0;
    int failures = 0;

    function automatic logic [33:0] alu_f(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [5:0]  f);
        logic [31:0] s;
        logic        o;
        s = 32'd0;
        o = 1'b0;
        case (f)
            6'd32: begin
                s = a + b;
                o = (a[31] == b[31]) && (s[31] != a[31]);
            end
            6'd34: begin
                s = a - b;
                o = (a[31] != b[31]) && (s[31] != a[31]);
            end
            6'd36: s = a & b;
            6'd37: s = a | b;
            default: s = 32'd0;
        endcase
        return {1'b0, o, s};
    endfunction

    assign {aluOvf_1, aluRes_1} = alu_f(in1_1, in2_1, fn_1);
    assign {aluOvf_3, aluRes_3} = alu_f(in1_3, in2_3, fn_3);

    alu_arbiter #(.WAIT_CYCLES(1)) dut1 (
        .clock(clock), .reset(reset1),
        .req0(req0), .req1(req1), .ack0(ack0_1), .ack1(ack1_1),
        .opA0(opA0), .opB0(opB0), .aluOp0(aluOp0), .funct0(funct0),
        .opA1(opA1), .opB1(opB1), .aluOp1(aluOp1), .funct1(funct1),
        .aluInput1(in1_1), .aluInput2(in2_1),
        .aluOpOut(op_1), .functOut(fn_1),
        .aluResult(aluRes_1), .aluOverflow(aluOvf_1),
        .result(res_1), .overflow(ovf_1),
        .resultValid(rv_1), .resultId(rid_1),
`ifdef ALU_ARB_OVF_STICKY_EN
        .ovfSticky(sticky_1), .ovfClear(ovfClear),
`endif
        .busy(busy_1)
    );

    alu_arbiter #(.WAIT_CYCLES(3)) dut3 (
        .clock(clock), .reset(reset3),
        .req0(req0), .req1(req1), .ack0(ack0_3), .ack1(ack1_3),
        .opA0(opA0), .opB0(opB0), .aluOp0(aluOp0), .funct0(funct0),
        .opA1(opA1), .opB1(opB1), .aluOp1(aluOp1), .funct1(funct1),
        .aluInput1(in1_3), .aluInput2(in2_3),
        .aluOpOut(op_3), .functOut(fn_3),
        .aluResult(aluRes_3), .aluOverflow(aluOvf_3),
        .result(res_3), .overflow(ovf_3),
        .resultValid(rv_3), .resultId(rid_3),
`ifdef ALU_ARB_OVF_STICKY_EN
        .ovfSticky(sticky_3), .ovfClear(ovfClear),
`endif
        .busy(busy_3)
    );

`ifndef ALU_ARB_OVF_STICKY_EN
    assign sticky_1 = 2'd0;
    assign sticky_3 = 2'd0;
`endif

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    typedef struct {
        logic        id;
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  op;
        logic [5:0]  f;
        logic [31:0] er;
        logic [1:0]  eo;
    } vec_t;

    vec_t vecs[6];

    // One complete operation on the WAIT_CYCLES=1 instance, from an idle cycle.
    task automatic run1(input vec_t v);
        if (v.id == 1'b0) begin
            opA0 = v.a; opB0 = v.b; aluOp0 = v.op; funct0 = v.f; req0 = 1'b1;
        end else begin
            opA1 = v.a; opB1 = v.b; aluOp1 = v.op; funct1 = v.f; req1 = 1'b1;
        end
        @(negedge clock);
        chk("w1_ack_own", v.id ? ack1_1 : ack0_1, 1);
        chk("w1_ack_other", v.id ? ack0_1 : ack1_1, 0);
        tick();
        req0 = 1'b0;
        req1 = 1'b0;
        @(negedge clock);
        chk("w1_in1", in1_1, v.a);
        chk("w1_in2", in2_1, v.b);
        chk("w1_funct", 32'(fn_1), 32'(v.f));
        chk("w1_aluop", 32'(op_1), 32'(v.op));
        chk("w1_rv_exec", 32'(rv_1), 0);
        chk("w1_busy", 32'(busy_1), 1);
        tick();
        @(negedge clock);
        chk("w1_rv_done", 32'(rv_1), 1);
        chk("w1_result", res_1, v.er);
        chk("w1_ovf", 32'(ovf_1), 32'(v.eo));
        chk("w1_rid", 32'(rid_1), 32'(v.id));
        tick();
    endtask

    initial begin
        vecs[0] = '{1'b0, 32'd5, 32'd7, 2'd2, 6'd32, 32'd12, 2'd0};
        vecs[1] = '{1'b1, 32'h7FFFFFFF, 32'd1, 2'd2, 6'd32, 32'h80000000, 2'd1};
        vecs[2] = '{1'b0, 32'd10, 32'd3, 2'd2, 6'd34, 32'd7, 2'd0};
        vecs[3] = '{1'b1, 32'hF0F0F0F0, 32'h0FF00FF0, 2'd2, 6'd36, 32'h00F000F0, 2'd0};
        vecs[4] = '{1'b0, 32'hFFFFFFFF, 32'd1, 2'd2, 6'd32, 32'd0, 2'd0};
        vecs[5] = '{1'b1, 32'h12345678, 32'h0000FFFF, 2'd0, 6'd37, 32'h1234FFFF, 2'd0};

        reset1 = 1'b1; reset3 = 1'b1;
        req0 = 1'b0; req1 = 1'b0;
        opA0 = 0; opB0 = 0; opA1 = 0; opB1 = 0;
        aluOp0 = 0; aluOp1 = 0; funct0 = 0; funct1 = 0;
        ovfClear = 2'd0;
        tick();
        tick();
        reset1 = 1'b0;

        // Idle with no requests.
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            chk("idle_busy", 32'(busy_1), 0);
            chk("idle_ack", {30'd0, ack1_1, ack0_1}, 0);
            chk("idle_rv", 32'(rv_1), 0);
            tick();
        end
        chk("rst_in1", in1_1, 0);
        chk("rst_in2", in2_1, 0);
        chk("rst_ctl", {24'd0, op_1, fn_1}, 0);
        chk("rst_result", res_1, 0);
        chk("rst_ovf_rid", {29'd0, ovf_1, rid_1}, 0);
        chk("rst_sticky", 32'(sticky_1), 0);

        for (int i = 0; i < 6; i++) begin
            run1(vecs[i]);
        end

`ifdef ALU_ARB_OVF_STICKY_EN
        @(negedge clock);
        chk("sticky_set", 32'(sticky_1), 32'd2);
        ovfClear = 2'b10;
        tick();
        ovfClear = 2'b00;
        @(negedge clock);
        chk("sticky_clr", 32'(sticky_1), 0);
        ovfClear = 2'b10;
        run1(vecs[1]);
        ovfClear = 2'b00;
        @(negedge clock);
        chk("sticky_set_wins", 32'(sticky_1), 32'd2);
`endif

        // Both requesters held: grants alternate starting from 0.
        reset1 = 1'b1;
        tick();
        reset1 = 1'b0;
        opA0 = 32'd100; opB0 = 32'd30; aluOp0 = 2'd2; funct0 = 6'd34;
        opA1 = 32'hFFFFFFFB; opB1 = 32'd10; aluOp1 = 2'd2; funct1 = 6'd34;
        req0 = 1'b1; req1 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            chk("rr_ack0", 32'(ack0_1), (k % 2 == 0) ? 1 : 0);
            chk("rr_ack1", 32'(ack1_1), (k % 2 == 1) ? 1 : 0);
            tick();
            tick();
            @(negedge clock);
            chk("rr_rv", 32'(rv_1), 1);
            chk("rr_rid", 32'(rid_1), k % 2);
            chk("rr_result", res_1, (k % 2 == 0) ? 32'd70 : 32'hFFFFFFF1);
            tick();
        end
        req0 = 1'b0; req1 = 1'b0;
        tick();

        // WAIT_CYCLES=3: hold window, valid timing and deferred second grant.
        reset1 = 1'b1;
        reset3 = 1'b0;
        opA0 = 32'h11; opB0 = 32'h22; aluOp0 = 2'd2; funct0 = 6'd32;
        req0 = 1'b1;
        @(negedge clock);
        chk("w3_ack0", 32'(ack0_3), 1);
        for (int t = 1; t <= 4; t++) begin
            tick();
            if (t == 1) req0 = 1'b0;
            if (t == 2) begin
                opA1 = 32'd3; opB1 = 32'd4; aluOp1 = 2'd2; funct1 = 6'd32;
                req1 = 1'b1;
            end
            @(negedge clock);
            chk("w3_hold_in1", in1_3, 32'h11);
            chk("w3_hold_in2", in2_3, 32'h22);
            chk("w3_rv", 32'(rv_3), (t == 4) ? 1 : 0);
            chk("w3_ack1_wait", 32'(ack1_3), 0);
            if (t == 4) begin
                chk("w3_result", res_3, 32'h33);
                chk("w3_rid", 32'(rid_3), 0);
            end
        end
        tick();
        @(negedge clock);
        chk("w3_ack1_late", 32'(ack1_3), 1);
        tick();
        req1 = 1'b0;
        tick();
        tick();
        tick();
        @(negedge clock);
        chk("w3_rv2", 32'(rv_3), 1);
        chk("w3_result2", res_3, 32'd7);
        chk("w3_rid2", 32'(rid_3), 1);
        tick();

        // Reset mid-operation drops it and restores priority to requester 0.
        opA0 = 32'h100; opB0 = 32'h1; funct0 = 6'd32;
        req0 = 1'b1;
        @(negedge clock);
        chk("rst_mid_ack0", 32'(ack0_3), 1);
        tick();
        req0 = 1'b0;
        reset3 = 1'b1;
        @(negedge clock);
        chk("rst_mid_busy", 32'(busy_3), 1);
        tick();
        reset3 = 1'b0;
        @(negedge clock);
        chk("rst_mid_busy0", 32'(busy_3), 0);
        chk("rst_mid_in1", in1_3, 0);
        chk("rst_mid_result", res_3, 0);
        chk("rst_mid_ctl", {24'd0, op_3, fn_3}, 0);
        for (int i = 0; i < 5; i++) begin
            chk("rst_mid_no_rv", 32'(rv_3), 0);
            tick();
            @(negedge clock);
        end
        tick();
        req0 = 1'b1; req1 = 1'b1;
        @(negedge clock);
        chk("rst_mid_prio_ack0", 32'(ack0_3), 1);
        chk("rst_mid_prio_ack1", 32'(ack1_3), 0);
        tick();
        req0 = 1'b0; req1 = 1'b0;
        repeat (5) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
